// File: rtl/dbg_cmd_responder.sv
// Debug host command responder: one-shot READ/WRITE to memory with ack timeout and HALT stall.
// Optional write readback verify is enabled with `define DBG_WRITE_VERIFY_EN.
module dbg_cmd_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cmd,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  output logic [15:0] data_out,
  output logic        err,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_HALT  = 2'b11;
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
`ifdef DBG_WRITE_VERIFY_EN
    , S_VREQ = 2'd3
`endif
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_prev_cmd;
  logic [1:0]  r_cmd;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_tmo;
  logic [15:0] r_data_out;
  logic        r_err;

  logic w_accept, w_busy, w_mreq, w_done_ok, w_timeout;
`ifdef DBG_WRITE_VERIFY_EN
  logic r_vgap;
  logic w_to_vreq, w_verify_ok;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = &{1'b0, mem_rdata[31:16]};
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy      = 1'b0;
    w_mreq      = 1'b0;
    w_done_ok   = 1'b0;
    w_timeout   = 1'b0;
`ifdef DBG_WRITE_VERIFY_EN
    w_to_vreq   = 1'b0;
    w_verify_ok = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // Only the first cycle after leaving NOP may start a command.
        if (r_prev_cmd == CMD_NOP && (cmd == CMD_READ || cmd == CMD_WRITE)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_busy = 1'b1;
        w_mreq = 1'b1;
        if (mem_ack) begin
          w_done_ok   = 1'b1;
          w_state_nxt = S_DONE;
`ifdef DBG_WRITE_VERIFY_EN
          if (r_cmd == CMD_WRITE) begin
            w_to_vreq   = 1'b1;
            w_state_nxt = S_VREQ;
          end
`endif
        end else if (r_tmo == TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
`ifdef DBG_WRITE_VERIFY_EN
      S_VREQ: begin
        // First VREQ cycle is a request gap so the readback is a separate handshake.
        w_busy = 1'b1;
        w_mreq = !r_vgap;
        if (!r_vgap) begin
          if (mem_ack) begin
            w_verify_ok = 1'b1;
            w_state_nxt = S_DONE;
          end else if (r_tmo == TMO_LAST) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
`endif
      S_DONE: begin
        if (cmd == CMD_NOP) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_cmd <= CMD_NOP;
      r_cmd      <= CMD_NOP;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_tmo      <= '0;
      r_data_out <= 16'h0000;
      r_err      <= 1'b0;
    end else begin
      r_prev_cmd <= cmd;
      if (w_accept) begin
        r_cmd   <= cmd;
        r_addr  <= addr_in;
        r_wdata <= data_in;
      end
      if (w_accept || w_done_ok)   r_tmo <= '0;
      else if (w_mreq && !mem_ack) r_tmo <= r_tmo + 8'd1;
      if (w_done_ok) begin
        r_data_out <= (r_cmd == CMD_READ) ? mem_rdata[15:0] : r_wdata[15:0];
        r_err      <= 1'b0;
      end
`ifdef DBG_WRITE_VERIFY_EN
      if (w_verify_ok) begin
        r_data_out <= mem_rdata[15:0];
        r_err      <= (mem_rdata != r_wdata);
      end
`endif
      if (w_timeout) begin
        r_data_out <= 16'hEEEE;
        r_err      <= 1'b1;
      end
    end
  end

`ifdef DBG_WRITE_VERIFY_EN
  always_ff @(posedge clk) begin
    if (reset) r_vgap <= 1'b0;
    else       r_vgap <= w_to_vreq;
  end
`endif

  assign mem_req   = w_mreq;
  assign mem_we    = (r_state == S_REQ) && (r_cmd == CMD_WRITE);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_stall = w_busy || (cmd == CMD_HALT);
  assign data_out  = r_data_out;
  assign err       = r_err;

endmodule

// File: tb/tb_dbg_cmd_responder.sv
// Scoreboard bench for dbg_cmd_responder: stimulus pushes expected transactions,
// a monitor pops one each time a mem_req phase ends.
module tb_dbg_cmd_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cmd;
  logic [31:0] addr_in, data_in;
  logic [15:0] data_out;
  logic        err, cpu_stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic mem_auto;
  int   ack_delay;
  int   mcnt = 0;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          len;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
  } exp_t;
  exp_t q[$];

  dbg_cmd_responder #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .addr_in(addr_in), .data_in(data_in),
    .data_out(data_out), .err(err), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] d, input logic e, input int len, input logic we,
                      input logic [31:0] a, input logic [31:0] wd, input int st);
    exp_t x;
    x.data = d; x.err = e; x.len = len; x.we = we; x.addr = a; x.wdata = wd; x.stall = st;
    q.push_back(x);
  endtask

  // Memory model: ack after ack_delay idle cycles of an ongoing request.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (mem_auto) mem_ack = (mcnt == ack_delay);
        mcnt++;
      end else begin
        if (mem_auto) mem_ack = 1'b0;
        mcnt = 0;
      end
    end
  end

  // Monitor: a mem_req phase ending is one observed transaction.
  initial begin
    int   run = 0;
    int   stall_cnt = 0;
    logic c_we;
    logic [31:0] c_addr, c_wdata;
    exp_t x;
    c_we = 1'b0; c_addr = '0; c_wdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (run == 0) begin
          c_we = mem_we; c_addr = mem_addr; c_wdata = mem_wdata;
        end
        run++;
      end else if (run > 0) begin
        if (q.size() == 0) begin
          chk("unexpected_txn", 32'(run), 32'd0);
        end else begin
          x = q.pop_front();
          chk("txn_data_out", {16'h0, data_out}, {16'h0, x.data});
          chk("txn_err", {31'h0, err}, {31'h0, x.err});
          chk("txn_req_len", 32'(run), 32'(x.len));
          chk("txn_we", {31'h0, c_we}, {31'h0, x.we});
          chk("txn_addr", c_addr, x.addr);
          if (x.we) chk("txn_wdata", c_wdata, x.wdata);
          chk("txn_stall_len", 32'(stall_cnt), 32'(x.stall));
        end
        run = 0;
        stall_cnt = 0;
      end
      if (cpu_stall && cmd != 2'b11) stall_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cmd = 2'b00; addr_in = '0; data_in = '0; mem_rdata = '0;
    mem_auto = 1'b1; ack_delay = 0;
    step(3);
    chk("rst_data_out", {16'h0, data_out}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_cpu_stall", {31'h0, cpu_stall}, 32'h0);
    reset = 1'b0;
    step(2);

    // READ, ack after 2 wait cycles; inputs change mid-request and must be ignored
    addr_in = 32'h10; mem_rdata = 32'h0000ABCD; ack_delay = 2;
    push(16'hABCD, 1'b0, 3, 1'b0, 32'h10, 32'h0, 3);
    cmd = 2'b01;
    step(1);
    addr_in = 32'hDEAD0000; data_in = 32'h5A5A5A5A;
    step(7);
    cmd = 2'b00;
    step(3);
    chk("read_hold_data", {16'h0, data_out}, 32'h0000ABCD);

    // WRITE with same-cycle ack
    addr_in = 32'h04; data_in = 32'h2A; ack_delay = 0;
    push(16'h002A, 1'b0, 1, 1'b1, 32'h04, 32'h2A, 1);
    cmd = 2'b10;
    step(4);
    cmd = 2'b00;
    step(2);

    // READ with no ack -> timeout
    addr_in = 32'h20; mem_rdata = 32'h12345678; ack_delay = 1000;
    push(16'hEEEE, 1'b1, 15, 1'b0, 32'h20, 32'h0, 15);
    cmd = 2'b01;
    step(25);
    chk("tmo_err_hold", {31'h0, err}, 32'h1);
    cmd = 2'b00;
    step(2);

    // READ held for 50 cycles, then 01->10 directly: a single transaction only
    addr_in = 32'h30; mem_rdata = 32'h00001234; ack_delay = 1;
    push(16'h1234, 1'b0, 2, 1'b0, 32'h30, 32'h0, 2);
    cmd = 2'b01;
    step(52);
    cmd = 2'b10;
    step(10);
    cmd = 2'b00;
    step(3);
    chk("hold_data_out", {16'h0, data_out}, 32'h00001234);
    chk("hold_err", {31'h0, err}, 32'h0);

    // HALT: stall only, no access, outputs unchanged
    cmd = 2'b11;
    #1;
    chk("halt_stall", {31'h0, cpu_stall}, 32'h1);
    chk("halt_no_req", {31'h0, mem_req}, 32'h0);
    step(3);
    cmd = 2'b00;
    step(2);
    chk("halt_release", {31'h0, cpu_stall}, 32'h0);
    chk("halt_data_out", {16'h0, data_out}, 32'h00001234);

`ifdef DBG_WRITE_VERIFY_EN
    // WRITE 0x15 with readback 0x14: two request phases, err from mismatch
    addr_in = 32'h50; data_in = 32'h15; mem_rdata = 32'h14; ack_delay = 0;
    push(16'h0015, 1'b0, 1, 1'b1, 32'h50, 32'h15, 1);
    push(16'h0014, 1'b1, 1, 1'b0, 32'h50, 32'h0, 2);
    cmd = 2'b10;
    step(6);
    cmd = 2'b00;
    step(2);
    chk("verify_err", {31'h0, err}, 32'h1);
`endif

    // Reset during 2nd REQ cycle, late ack afterwards must be ignored
    mem_auto = 1'b0; mem_ack = 1'b0;
    addr_in = 32'h40; mem_rdata = 32'h0000BEEF;
    push(16'h0000, 1'b0, 2, 1'b0, 32'h40, 32'h0, 2);
    cmd = 2'b01;
    step(2);
    reset = 1'b1; cmd = 2'b00;
    step(1);
    reset = 1'b0; mem_ack = 1'b1;
    step(1);
    mem_ack = 1'b0;
    step(3);
    chk("rstmid_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rstmid_stall", {31'h0, cpu_stall}, 32'h0);
    chk("rstmid_data_out", {16'h0, data_out}, 32'h0);
    chk("rstmid_err", {31'h0, err}, 32'h0);
    mem_auto = 1'b1;

    // Back in IDLE: a fresh READ is accepted
    addr_in = 32'h60; mem_rdata = 32'hFFFF5555; ack_delay = 0;
    push(16'h5555, 1'b0, 1, 1'b0, 32'h60, 32'h0, 1);
    cmd = 2'b01;
    step(4);
    cmd = 2'b00;
    step(4);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbg_cmd_responder.md
DBG_CMD_RESPONDER -- requirements
Module: dbg_cmd_responder

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 15, giving the maximum wait in cycles for mem_ack before a request is aborted (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port cmd, input, 2 bits: host command; 00 is NOP, 01 is READ, 10 is WRITE, 11 is HALT.
REQ-005 The block SHALL have port addr_in, input, 32 bits: host target address.
REQ-006 The block SHALL have port data_in, input, 32 bits: host write data.
REQ-007 The block SHALL have port data_out, output, 16 bits: result shown on the 4-digit display.
REQ-008 The block SHALL have port err, output, 1 bit: the last command timed out, or failed readback when REQ-024 applies.
REQ-009 The block SHALL have port cpu_stall, output, 1 bit: freezes the core pipeline.
REQ-010 The block SHALL have ports mem_req (1 bit), mem_we (1 bit), mem_addr (32 bits) and mem_wdata (32 bits) as outputs, forming the memory request side.
REQ-011 The block SHALL have ports mem_ack (1 bit) and mem_rdata (32 bits) as inputs, forming the memory response side.

Function
REQ-012 The FSM SHALL have states IDLE, REQ, VREQ and DONE; VREQ exists only when REQ-024 applies.
REQ-013 Command acceptance SHALL occur in IDLE only, when cmd is 01 or 10 and the registered cmd of the previous cycle was 00 (one-shot on leaving NOP).
- On acceptance, cmd, addr_in and data_in SHALL be latched and the FSM SHALL go to REQ.
REQ-014 In REQ, the block SHALL hold mem_req=1 and hold mem_we, mem_addr and mem_wdata stable from the latched values.
- Input changes during REQ SHALL be ignored.
REQ-015 Completion of REQ SHALL be the rising edge at which mem_req=1 and mem_ack=1.
- mem_req SHALL be 0 in the following cycle.
- A same-cycle ack gives a minimum latency of 1 cycle from entering REQ.
REQ-016 On READ completion, data_out SHALL be set to mem_rdata[15:0] and err SHALL be cleared.
- On WRITE completion, data_out SHALL be set to data_in_latched[15:0] and err SHALL be cleared.
REQ-017 A timeout counter of 8 bits SHALL clear on entry to REQ or VREQ and increment each cycle without ack.
- When the count reaches TIMEOUT_CYCLES with no ack, mem_req SHALL drop, data_out SHALL be set to 16'hEEEE, err SHALL be set to 1, and the FSM SHALL go to DONE.
- An ack arriving in the same cycle as the timeout SHALL win and complete the request normally.
REQ-018 DONE SHALL go to IDLE once cmd is 00.
- A non-NOP cmd held after completion SHALL never re-trigger.
REQ-019 cpu_stall SHALL be 1 in REQ and VREQ, and in any cycle where cmd is 11.
- cpu_stall SHALL be 0 otherwise.
- HALT issues no memory access and leaves data_out and err unchanged.
REQ-020 A 01 to 10 transition without passing through 00 SHALL NOT start a command.
REQ-021 data_out and err SHALL hold their values between commands.
REQ-022 mem_we SHALL be 1 only while mem_req=1 for a WRITE; mem_addr and mem_wdata are don't-care when mem_req=0.

Reset
REQ-023 While reset=1 at a rising edge, the block SHALL set: FSM to IDLE, previous-cmd register to 00, data_out to 16'h0000, err to 0, mem_req to 0, mem_we to 0, cpu_stall to 0, and timeout counter to 0.
- Reset mid-REQ SHALL abandon the transaction; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-024 When macro DBG_WRITE_VERIFY_EN is defined, a WRITE completion SHALL go to VREQ instead of DONE.
- VREQ SHALL issue a read (mem_we=0) to the same address, with the same handshake and timeout rules as REQ.
- On VREQ completion, data_out SHALL be set to mem_rdata[15:0] and err SHALL be set to (mem_rdata != data_in_latched).
- Without the macro, VREQ SHALL not exist, WRITE SHALL finish per REQ-016, and the err source is timeout only.

Verification
REQ-025 The bench SHALL cover: cmd 00->01, addr 0x10, memory acks after 2 cycles with rdata 0x0000ABCD -> mem_req high for 3 cycles, data_out=0xABCD, err=0, cpu_stall high for 3 cycles.
REQ-026 The bench SHALL cover: cmd 00->10, addr 0x04, data 0x2A, same-cycle ack -> one-cycle mem_req with mem_we=1, mem_wdata=0x2A, data_out=0x002A.
REQ-027 The bench SHALL cover: READ with mem_ack tied low and TIMEOUT_CYCLES=15 -> mem_req drops after 15 cycles, data_out=0xEEEE, err=1.
REQ-028 The bench SHALL cover: cmd held at 01 for 50 cycles after completion, then 01->10 directly -> exactly one transaction.
REQ-029 The bench SHALL cover: reset asserted in the 2nd cycle of REQ, then ack one cycle later -> mem_req=0, data_out=0x0000, FSM IDLE, no update.
REQ-030 The bench SHALL cover, with DBG_WRITE_VERIFY_EN: WRITE 0x15 with readback 0x14 -> two mem_req phases, data_out=0x0014, err=1.
